// File: rtl/data_mem_port.sv
// data_mem_port: load/store endpoint driving a request/response data-memory bus
module data_mem_port #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_rd_en,
    input  logic                  mem_wr_en,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wr_data,
    output logic                  stall,
    output logic [31:0]           load_data,
    output logic                  access_fault,
    output logic                  bus_timeout,
    output logic                  bus_req_valid,
    input  logic                  bus_req_ready,
    output logic                  bus_req_we,
    output logic [ADDR_WIDTH-1:0] bus_req_addr,
    output logic [31:0]           bus_req_wdata,
    output logic [3:0]            bus_req_be,
    input  logic                  bus_rsp_valid,
    input  logic [31:0]           bus_rsp_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;
    state_t                state_q, state_d;
    logic                  we_q, we_d, fault_q, fault_d, tmo_q, tmo_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            be_q, be_d;
    logic [31:0]           wdata_q, wdata_d, load_q, load_d;
    logic [2:0]            f3_q, f3_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  req, f3_ok, align_ok, legal;
    logic [3:0]            be_n;
    logic [31:0]           wd_n, sh, ext;
    // loads win when both enables are high, so legality follows the load funct3 set
    assign req      = mem_rd_en | mem_wr_en;
    assign f3_ok    = mem_rd_en ? (funct3[1:0] != 2'b11 && !(funct3[2] && funct3[1]))
                                : (!funct3[2] && funct3[1:0] != 2'b11);
    assign align_ok = funct3[1] ? (addr[1:0] == 2'b00) : funct3[0] ? !addr[0] : 1'b1;
    assign legal    = req && f3_ok && align_ok;
    assign be_n     = funct3[1] ? 4'hF : funct3[0] ? (addr[1] ? 4'hC : 4'h3) : 4'b0001 << addr[1:0];
    assign wd_n     = funct3[1] ? wr_data : funct3[0] ? {2{wr_data[15:0]}} : {4{wr_data[7:0]}};
    // halfwords are aligned, so one byte-granular shift serves both byte and half lanes
    assign sh       = bus_rsp_rdata >> {addr_q[1:0], 3'b000};
    assign ext      = f3_q[1] ? bus_rsp_rdata
                    : f3_q[0] ? {{16{~f3_q[2] & sh[15]}}, sh[15:0]}
                              : {{24{~f3_q[2] & sh[7]}}, sh[7:0]};
    assign stall         = (state_q == IDLE && legal) || state_q == REQ || state_q == WAIT_RSP;
    assign bus_req_valid = state_q == REQ;
    assign bus_req_we    = we_q;
    assign bus_req_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign bus_req_wdata = wdata_q;
    assign bus_req_be    = be_q;
    assign load_data     = load_q;
    assign access_fault  = fault_q;
    assign bus_timeout   = tmo_q;
    // transaction sequencing: accept, request, await response or timeout, release
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        cnt_d   = cnt_q;
        load_d  = load_q;
        fault_d = 1'b0;
        tmo_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (legal) begin
                    state_d = REQ;
                    we_d    = mem_wr_en & ~mem_rd_en;
                    addr_d  = addr;
                    be_d    = be_n;
                    wdata_d = wd_n;
                    f3_d    = funct3;
                end else begin
                    fault_d = req;
                end
            end
            REQ: begin
                if (bus_req_ready) begin
                    state_d = we_q ? DONE : WAIT_RSP;
                    cnt_d   = '0;
                end
            end
            WAIT_RSP: begin
                if (bus_rsp_valid) begin
                    load_d  = ext;
                    state_d = DONE;
                end else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // state and latched request fields; reset abandons any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            cnt_q   <= '0;
            load_q  <= '0;
            fault_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            fault_q <= fault_d;
            tmo_q   <= tmo_d;
        end
    end
endmodule
